// File: rtl/colour_pkg.sv
// Shared types for the colour sequencer: FSM state encoding, 3-bit colour codes
// and the converter's RGB width.
package colour_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTO = 2'd1,
    MAN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BLACK   = 3'd0,
    BLUE    = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    RED     = 3'd4,
    MAGENTA = 3'd5,
    YELLOW  = 3'd6,
    WHITE   = 3'd7
  } colour_e;

  typedef logic [2:0] colour_t;

  localparam int RGB_W = 24;

  // Auto-cycle order simply walks the codes, wrapping WHITE back to BLACK.
  function automatic colour_t next_colour(input colour_t c);
    return c + 3'd1;
  endfunction

endpackage

// File: rtl/colour_sequencer_if.sv
// Host/converter-facing signal bundle of the colour sequencer; the sequencer
// takes the slave view, whoever drives requests and the converter takes master.
interface colour_sequencer_if
  import colour_pkg::*;
#(
  parameter int DWELL_W = 8
);

  logic               run;
  logic [DWELL_W-1:0] dwell;
  logic               req_valid;
  logic [2:0]         req_colour;
  logic               req_ready;
  logic [2:0]         colour;
  logic               conv_enable;
  logic [RGB_W-1:0]   rgb_in;
  logic [RGB_W-1:0]   rgb_out;
  logic               rgb_valid;
  logic [1:0]         state;

  modport master (
    output run, dwell, req_valid, req_colour, rgb_in,
    input  req_ready, colour, conv_enable, rgb_out, rgb_valid, state
  );

  modport slave (
    input  run, dwell, req_valid, req_colour, rgb_in,
    output req_ready, colour, conv_enable, rgb_out, rgb_valid, state
  );

endinterface

// File: rtl/colour_sequencer_dwell_timer.sv
// Loadable dwell down-counter; a zero dwell is treated as one cycle, so the
// reload value is max(dwell,1)-1 and the counter never wraps.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;
  logic [DWELL_W-1:0] reload;

  always_comb begin
    reload  = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    count_d = count_q;
    if (load_i) begin
      count_d = reload;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/colour_sequencer.sv
// Drives the RGB converter's colour/enable, arbitrating between the auto-cycle
// generator and manual host requests, and captures the settled RGB result.
module colour_sequencer
  import colour_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  colour_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  colour_t          colour_q, colour_d;
  colour_t          auto_colour_q, auto_colour_d;
  logic             enable_q, enable_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             valid_q, valid_d;
  logic [SETTLE-1:0] settle_q, settle_d;

  logic load;
  logic dec;
  logic push;
  logic accept;
  logic cnt_zero;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .dec_i   (dec),
    .dwell_i (bus.dwell),
    .zero_o  (cnt_zero)
  );

  // A manual request preempts an auto step, but the auto pointer still
  // advances if the dwell happened to expire on the same cycle.
  always_comb begin
    state_d       = state_q;
    colour_d      = colour_q;
    auto_colour_d = auto_colour_q;
    enable_d      = enable_q;
    load          = 1'b0;
    dec           = 1'b0;
    push          = 1'b0;
    accept        = bus.req_valid && (state_q != MAN);

    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (accept) begin
          state_d  = MAN;
          colour_d = bus.req_colour;
          enable_d = 1'b1;
          load     = 1'b1;
          push     = 1'b1;
        end else if (bus.run) begin
          state_d  = AUTO;
          colour_d = auto_colour_q;
          enable_d = 1'b1;
          load     = 1'b1;
          push     = 1'b1;
        end
      end
      AUTO: begin
        if (accept) begin
          state_d  = MAN;
          colour_d = bus.req_colour;
          enable_d = 1'b1;
          load     = 1'b1;
          push     = 1'b1;
          if (cnt_zero) begin
            auto_colour_d = next_colour(auto_colour_q);
          end
        end else if (!bus.run) begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (cnt_zero) begin
          auto_colour_d = next_colour(auto_colour_q);
          colour_d      = next_colour(auto_colour_q);
          load          = 1'b1;
          push          = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      MAN: begin
        if (!cnt_zero) begin
          dec = 1'b1;
        end else if (bus.run) begin
          state_d  = AUTO;
          colour_d = auto_colour_q;
          enable_d = 1'b1;
          load     = 1'b1;
          push     = 1'b1;
        end else begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase

    settle_d = (settle_q << 1) | SETTLE'(push);
    valid_d  = settle_q[SETTLE-1] && enable_q;
    rgb_d    = valid_d ? bus.rgb_in : rgb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      colour_q      <= BLACK;
      auto_colour_q <= BLACK;
      enable_q      <= 1'b0;
      rgb_q         <= '0;
      valid_q       <= 1'b0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      colour_q      <= colour_d;
      auto_colour_q <= auto_colour_d;
      enable_q      <= enable_d;
      rgb_q         <= rgb_d;
      valid_q       <= valid_d;
      settle_q      <= settle_d;
    end
  end

  assign bus.req_ready   = (state_q != MAN);
  assign bus.colour      = colour_q;
  assign bus.conv_enable = enable_q;
  assign bus.rgb_out     = rgb_q;
  assign bus.rgb_valid   = valid_q;
  assign bus.state       = state_q;

endmodule
